// File: rtl/uc_compara_tiros_e_asteroides.sv
// Shot-vs-asteroid comparison control unit: scans every asteroid against every shot,
// destroys matching active asteroids, consumes the shot and pulses fim when the scan ends.
module uc_compara_tiros_e_asteroides #(
  parameter int unsigned N_AST = 16,
  parameter int unsigned AST_W = 4,
  parameter int unsigned N_TIR = 4,
  parameter int unsigned TIR_W = 2,
  parameter int unsigned POS_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             iniciar_comparacao_tiros,
  input  logic [POS_W-1:0] asteroide_pos,
  input  logic             asteroide_ativo,
  input  logic [POS_W-1:0] tiro_pos,
  input  logic             tiro_ativo,
  output logic [AST_W-1:0] asteroide_addr,
  output logic [TIR_W-1:0] tiro_addr,
  output logic             enable_load_asteroide,
  output logic             new_destruido_asteroide,
  output logic             enable_load_tiro,
  output logic             new_ativo_tiro,
  output logic             pontua,
  output logic             fim_compara_tiros_e_asteroides,
  output logic [4:0]       db_estado
);

  localparam logic [AST_W-1:0] AST_MAX = AST_W'(N_AST - 1);
  localparam logic [TIR_W-1:0] TIR_MAX = TIR_W'(N_TIR - 1);

  typedef enum logic [4:0] {
    st_inicio   = 5'd0,
    st_espera   = 5'd1,
    st_zera     = 5'd2,
    st_compara  = 5'd3,
    st_destroi  = 5'd4,
    st_inc_ast  = 5'd5,
    st_inc_tiro = 5'd6,
    st_fim      = 5'd7
  } estado_t;

  estado_t estado, estado_next;

  logic       hit_c;
  logic       ast_ultimo_c;
  logic       el_ast_nx, nd_ast_nx, el_tiro_nx, pontua_nx, fim_nx;
  logic [4:0] db_nx;

  assign hit_c        = asteroide_ativo & tiro_ativo & (asteroide_pos == tiro_pos);
  assign ast_ultimo_c = (asteroide_addr == AST_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) estado <= st_inicio;
    else        estado <= estado_next;
  end

  // Next state plus the output decode of that next state, so outputs come out of flops.
  always_comb begin
    estado_next = st_inicio;
    el_ast_nx   = 1'b0;
    nd_ast_nx   = 1'b0;
    el_tiro_nx  = 1'b0;
    pontua_nx   = 1'b0;
    fim_nx      = 1'b0;
    db_nx       = 5'd0;

    case (estado)
      st_inicio:   estado_next = st_espera;
      st_espera:   estado_next = iniciar_comparacao_tiros ? st_zera : st_espera;
      st_zera:     estado_next = st_compara;
      st_compara: begin
        if (hit_c)
          estado_next = st_destroi;
        else if (!asteroide_ativo || (tiro_addr == TIR_MAX))
          estado_next = ast_ultimo_c ? st_fim : st_inc_ast;
        else
          estado_next = st_inc_tiro;
      end
      st_destroi:  estado_next = ast_ultimo_c ? st_fim : st_inc_ast;
      st_inc_ast:  estado_next = st_compara;
      st_inc_tiro: estado_next = st_compara;
      st_fim:      estado_next = st_espera;
      default:     estado_next = st_inicio;
    endcase

    case (estado_next)
      st_espera:   db_nx = 5'd1;
      st_zera:     db_nx = 5'd2;
      st_compara:  db_nx = 5'd3;
      st_destroi: begin
        db_nx      = 5'd4;
        el_ast_nx  = 1'b1;
        nd_ast_nx  = 1'b1;
        el_tiro_nx = 1'b1;
        pontua_nx  = 1'b1;
      end
      st_inc_ast:  db_nx = 5'd5;
      st_inc_tiro: db_nx = 5'd6;
      st_fim: begin
        db_nx  = 5'd7;
        fim_nx = 1'b1;
      end
      default:     db_nx = 5'd0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable_load_asteroide          <= 1'b0;
      new_destruido_asteroide        <= 1'b0;
      enable_load_tiro               <= 1'b0;
      new_ativo_tiro                 <= 1'b0;
      pontua                         <= 1'b0;
      fim_compara_tiros_e_asteroides <= 1'b0;
      db_estado                      <= 5'd0;
    end else begin
      enable_load_asteroide          <= el_ast_nx;
      new_destruido_asteroide        <= nd_ast_nx;
      enable_load_tiro               <= el_tiro_nx;
      new_ativo_tiro                 <= 1'b0;
      pontua                         <= pontua_nx;
      fim_compara_tiros_e_asteroides <= fim_nx;
      db_estado                      <= db_nx;
    end
  end

  // Address counters: cleared in zera, stepped in the inc states, held otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      asteroide_addr <= '0;
      tiro_addr      <= '0;
    end else begin
      case (estado)
        st_zera: begin
          asteroide_addr <= '0;
          tiro_addr      <= '0;
        end
        st_inc_ast: begin
          asteroide_addr <= asteroide_addr + AST_W'(1);
          tiro_addr      <= '0;
        end
        st_inc_tiro: tiro_addr <= tiro_addr + TIR_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uc_compara_tiros_e_asteroides.sv
// Bench for uc_compara_tiros_e_asteroides: register-bank environment, a scan-level
// reference model (expected hits and latency) and a per-cycle output checker.
module tb_uc_compara_tiros_e_asteroides;

  localparam int N_AST = 16;
  localparam int N_TIR = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic [7:0] asteroide_pos, tiro_pos;
  logic       asteroide_ativo, tiro_ativo;
  logic [3:0] asteroide_addr;
  logic [1:0] tiro_addr;
  logic       el_ast, nd_ast, el_tiro, na_tiro, pontua, fim;
  logic [4:0] db_estado;

  uc_compara_tiros_e_asteroides dut (
    .clock(clock), .reset(reset),
    .iniciar_comparacao_tiros(iniciar),
    .asteroide_pos(asteroide_pos), .asteroide_ativo(asteroide_ativo),
    .tiro_pos(tiro_pos), .tiro_ativo(tiro_ativo),
    .asteroide_addr(asteroide_addr), .tiro_addr(tiro_addr),
    .enable_load_asteroide(el_ast), .new_destruido_asteroide(nd_ast),
    .enable_load_tiro(el_tiro), .new_ativo_tiro(na_tiro),
    .pontua(pontua), .fim_compara_tiros_e_asteroides(fim),
    .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Register banks (environment) and the configuration image loaded into them.
  logic [7:0] b_pos_a [N_AST];
  logic       b_loaded [N_AST];
  logic       b_dest [N_AST];
  logic [7:0] b_pos_t [N_TIR];
  logic       b_tact [N_TIR];
  logic [7:0] c_pos_a [N_AST];
  logic       c_loaded [N_AST];
  logic [7:0] c_pos_t [N_TIR];
  logic       c_tact [N_TIR];
  logic       cfg_load = 1'b0;

  assign asteroide_pos   = b_pos_a[asteroide_addr];
  assign asteroide_ativo = b_loaded[asteroide_addr] && !b_dest[asteroide_addr];
  assign tiro_pos        = b_pos_t[tiro_addr];
  assign tiro_ativo      = b_tact[tiro_addr];

  always @(posedge clock) begin
    if (cfg_load) begin
      for (int i = 0; i < N_AST; i++) begin
        b_pos_a[i] <= c_pos_a[i]; b_loaded[i] <= c_loaded[i]; b_dest[i] <= 1'b0;
      end
      for (int i = 0; i < N_TIR; i++) begin
        b_pos_t[i] <= c_pos_t[i]; b_tact[i] <= c_tact[i];
      end
    end else begin
      if (el_ast)  b_dest[asteroide_addr] <= nd_ast;
      if (el_tiro) b_tact[tiro_addr]      <= na_tiro;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct { int a; int t; } hit_t;
  hit_t exp_q [$];
  hit_t e;

  logic chk_en = 1'b0;
  logic scan_on = 1'b0;
  logic done = 1'b0;
  int   cnt = 0, exp_lat = 0, last_lat = 0;
  int   pontua_count = 0, fim_count = 0;
  int   last_ast = -1, last_tir = -1, fim_ast = -1;

  // Compare process: every write and every fim against the model's expectations.
  always @(negedge clock) begin
    if (chk_en && reset) begin
      if (scan_on) cnt++;
      if (el_ast || el_tiro || pontua || nd_ast || na_tiro) begin
        if (scan_on && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("destroi", {asteroide_addr, tiro_addr, el_ast, nd_ast, el_tiro, na_tiro, pontua, db_estado},
                {4'(e.a), 2'(e.t), 5'b11101, 5'd4});
        end else check("unexpected_write", 1, 0);
        if (pontua) pontua_count++;
        last_ast = int'(asteroide_addr);
        last_tir = int'(tiro_addr);
      end
      if (fim) begin
        fim_count++;
        if (scan_on) begin
          check("fim_latency", cnt, exp_lat);
          check("writes_pending", exp_q.size(), 0);
          last_lat = cnt;
          fim_ast  = int'(asteroide_addr);
          scan_on  = 1'b0;
          done     = 1'b1;
        end else check("unexpected_fim", 1, 0);
      end else if (!scan_on) check("idle_state", db_estado, 5'd1);
    end
  end

  // Reference model: scan rules applied to the current bank contents.
  task automatic model_scan(output int lat);
    logic tact [N_TIR];
    int c, hit;
    for (int t = 0; t < N_TIR; t++) tact[t] = b_tact[t];
    lat = 2;
    for (int a = 0; a < N_AST; a++) begin
      if (!(b_loaded[a] && !b_dest[a])) c = 1;
      else begin
        hit = -1;
        for (int t = 0; t < N_TIR; t++)
          if (hit < 0 && tact[t] && b_pos_a[a] == b_pos_t[t]) hit = t;
        if (hit >= 0) begin
          c = 2 * hit + 2;
          tact[hit] = 1'b0;
          exp_q.push_back('{a: a, t: hit});
        end else c = 2 * N_TIR - 1;
      end
      if (a != N_AST - 1) c++;
      lat += c;
    end
  endtask

  task automatic clear_cfg();
    for (int i = 0; i < N_AST; i++) begin c_pos_a[i] = 8'(i); c_loaded[i] = 1'b0; end
    for (int i = 0; i < N_TIR; i++) begin c_pos_t[i] = 8'(8'hC0 + i); c_tact[i] = 1'b0; end
  endtask

  task automatic load_cfg();
    @(negedge clock); #1 cfg_load = 1'b1;
    @(negedge clock); #1 cfg_load = 1'b0;
  endtask

  // One scan: start pulse, optional stray re-pulse at cycle rp, bounded wait for fim.
  task automatic run_scan(input int rp);
    int lat;
    model_scan(lat);
    @(negedge clock); #1;
    done = 1'b0; cnt = 0; exp_lat = lat; scan_on = 1'b1; iniciar = 1'b1;
    @(negedge clock); #1 iniciar = 1'b0;
    for (int i = 2; i < lat + 20 && !done; i++) begin
      @(negedge clock); #1 iniciar = (i == rp);
    end
    iniciar = 1'b0;
    if (!done) begin
      check("scan_timeout", 0, 1);
      scan_on = 1'b0;
      exp_q.delete();
    end
  endtask

  int p0, f0;

  initial begin
    clear_cfg();
    for (int i = 0; i < N_AST; i++) begin b_pos_a[i] = 8'h0; b_loaded[i] = 1'b0; b_dest[i] = 1'b0; end
    for (int i = 0; i < N_TIR; i++) begin b_pos_t[i] = 8'h0; b_tact[i] = 1'b0; end

    // T1: reset state, then reset in the middle of a scan
    repeat (2) @(negedge clock);
    check("reset_outputs", {asteroide_addr, tiro_addr, el_ast, nd_ast, el_tiro, na_tiro, pontua, fim, db_estado}, 0);
    #1 reset = 1'b1;
    @(negedge clock);
    check("after_reset_db", db_estado, 5'd1);
    for (int i = 0; i < N_AST; i++) begin c_loaded[i] = 1'b1; c_pos_a[i] = 8'h40 + 8'(i); end
    for (int i = 0; i < N_TIR; i++) c_tact[i] = 1'b1;
    load_cfg();
    @(negedge clock); #1 iniciar = 1'b1;
    @(negedge clock); #1 iniciar = 1'b0;
    repeat (9) @(negedge clock);
    check("mid_scan_busy", (db_estado != 5'd1) ? 1 : 0, 1);
    #1 reset = 1'b0;
    #1 check("mid_scan_reset", {asteroide_addr, tiro_addr, el_ast, nd_ast, el_tiro, na_tiro, pontua, fim, db_estado}, 0);
    repeat (2) @(negedge clock);
    check("reset_held", {asteroide_addr, tiro_addr, el_ast, nd_ast, el_tiro, na_tiro, pontua, fim, db_estado}, 0);
    #1 reset = 1'b1;
    @(negedge clock);
    check("release_db", db_estado, 5'd1);
    chk_en = 1'b1;

    // T2: nothing active
    clear_cfg(); load_cfg();
    p0 = pontua_count;
    run_scan(-1);
    check("t2_latency", last_lat, 33);
    check("t2_no_pontua", pontua_count - p0, 0);

    // T3: single hit, asteroid 2 / shot 1 at 0x35; decoys that must not match
    clear_cfg();
    c_loaded[2] = 1'b1; c_pos_a[2] = 8'h35;
    c_loaded[5] = 1'b0; c_pos_a[5] = 8'h35;
    c_tact[0] = 1'b1; c_pos_t[0] = 8'h34;
    c_tact[1] = 1'b1; c_pos_t[1] = 8'h35;
    load_cfg();
    p0 = pontua_count;
    run_scan(-1);
    check("t3_latency", last_lat, 36);
    check("t3_hit_addr", {last_ast[3:0], last_tir[1:0]}, {4'd2, 2'd1});
    check("t3_pontua", pontua_count - p0, 1);
    check("t3_banks", {b_dest[2], b_tact[1], b_tact[0]}, 3'b101);

    // T4: two asteroids at 0x11, one shot at 0x11
    clear_cfg();
    c_loaded[0] = 1'b1; c_pos_a[0] = 8'h11;
    c_loaded[3] = 1'b1; c_pos_a[3] = 8'h11;
    c_tact[2] = 1'b1; c_pos_t[2] = 8'h11;
    load_cfg();
    p0 = pontua_count;
    run_scan(-1);
    check("t4_dest", {b_dest[0], b_dest[3]}, 2'b10);
    check("t4_pontua", pontua_count - p0, 1);

    // T5: stray start pulse mid-scan ignored; a later pulse starts a second scan
    clear_cfg();
    c_loaded[7] = 1'b1; c_pos_a[7] = 8'hA5;
    c_tact[3] = 1'b1; c_pos_t[3] = 8'hA5;
    load_cfg();
    f0 = fim_count;
    run_scan(5);
    repeat (12) @(negedge clock);
    check("t5_one_fim", fim_count - f0, 1);
    run_scan(-1);
    check("t5_second_scan", fim_count - f0, 2);

    // T6: hit at the maximum addresses, counters must not wrap before fim
    clear_cfg();
    c_loaded[15] = 1'b1; c_pos_a[15] = 8'hFF;
    c_pos_a[0] = 8'h00; c_tact[1] = 1'b1; c_pos_t[1] = 8'h00;
    c_tact[3] = 1'b1; c_pos_t[3] = 8'hFF;
    load_cfg();
    run_scan(-1);
    check("t6_latency", last_lat, 40);
    check("t6_hit_addr", {last_ast[3:0], last_tir[1:0]}, {4'd15, 2'd3});
    check("t6_fim_addr", fim_ast, 15);

    // T7: mixed pattern, several hits and misses, model only
    clear_cfg();
    for (int i = 0; i < N_AST; i += 3) begin c_loaded[i] = 1'b1; c_pos_a[i] = 8'h20 + 8'(i % 4); end
    for (int i = 0; i < N_TIR; i++) begin c_tact[i] = 1'b1; c_pos_t[i] = 8'h20 + 8'(i); end
    load_cfg();
    p0 = pontua_count;
    run_scan(-1);
    check("t7_pontua", pontua_count - p0, 4);

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
